uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter between NUM_REQ byte sources with round-robin
//   fairness. Latches the winning byte and fires a one-cycle DV pulse into the
//   transmitter. Waits for the transmitter's done pulse, with a watchdog.
//   Enforces an inter-frame idle gap before the next grant.
//   Sits between the protocol/packet blocks and the single uart_tx instance.
// PARAMETERS
//   NUM_REQ       4     number of requesters, 2..8
//   TIMEOUT_CLKS  6000  max clocks to wait for i_Tx_Done; must be < 65536 (>1 frame @434 clk/bit)
//   GAP_CLKS      0     idle clocks inserted after each frame; 0 = no gap
// PORTS
//   i_Clock      in   1          system clock
//   i_Rst_L      in   1          async active-low reset
//   i_Req        in   NUM_REQ    per-source request; hold with byte until ack
//   i_Req_Byte   in   8*NUM_REQ  byte of source k at [8k+7:8k]
//   o_Ack        out  NUM_REQ    one-hot, 1-cycle pulse: byte of source k accepted
//   o_Tx_DV      out  1          1-cycle launch pulse to transmitter
//   o_Tx_Byte    out  8          byte to transmitter; stable from DV until next grant
//   i_Tx_Active  in   1          transmitter busy (status only, not used for sequencing)
//   i_Tx_Done    in   1          transmitter 1-cycle frame-complete pulse
//   o_Grant_Id   out  3          index of current/last granted source
//   o_Busy       out  1          high in every state except IDLE
//   o_Timeout    out  1          1-cycle pulse when watchdog expires
// BEHAVIOUR
//   Reset (async, i_Rst_L=0): state=IDLE, rr_ptr=0, cnt=0.
//     All outputs 0: o_Ack, o_Tx_DV, o_Tx_Byte, o_Grant_Id, o_Busy, o_Timeout.
//     Reset mid-frame: the transmitter is left to finish on its own.
//     After release, the arbiter ignores any stray i_Tx_Done received in IDLE.
//   States: IDLE -> WAIT_DONE -> GAP -> IDLE (GAP skipped when GAP_CLKS=0).
//   IDLE: if |i_Req, select k = first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
//     Next edge: o_Tx_Byte<=byte k, o_Grant_Id<=k, o_Tx_DV<=1, o_Ack<=1<<k, cnt<=0, ->WAIT_DONE.
//     Latency: request sampled at edge n -> DV/ack high during cycle n+1.
//     No requests: stay IDLE, outputs idle.
//   WAIT_DONE: o_Tx_DV and o_Ack are 0 after their single cycle; cnt increments each clock.
//     i_Tx_Done=1: rr_ptr<=(k+1) mod NUM_REQ, cnt<=0, ->GAP (or ->IDLE if GAP_CLKS=0).
//     cnt==TIMEOUT_CLKS-1 without done: o_Timeout pulse, rr_ptr advance as above, ->GAP/IDLE.
//     Done and timeout in same cycle: done wins, no o_Timeout.
//   GAP: count GAP_CLKS clocks (cnt 0..GAP_CLKS-1), then ->IDLE. Requests are not sampled in GAP.
//   Fairness: a continuously requesting source waits at most NUM_REQ-1 frames.
//   Withdrawal: a source dropping i_Req before ack is simply not selected; no error.
//   Source contract: source sees ack and may present a new byte the next cycle;
//     that byte is not accepted before the following IDLE visit.
//   i_Req bits above NUM_REQ-1 do not exist.
//   Any i_Tx_Done outside WAIT_DONE is ignored.
//   Illegal state encoding -> IDLE.
//   cnt is 16 bits wide and never wraps.
// TESTING
//   1. Single source: i_Req=4'b0001, byte 0xA5.
//      -> DV + ack[0] one cycle later, o_Tx_Byte=0xA5.
//      Done after 10 clk -> IDLE, rr_ptr=1.
//   2. All four requesting continuously, bytes 0x10..0x13.
//      -> grants 0,1,2,3,0,... and the uart_tx model emits 10,11,12,13,10.
//   3. Source 2 only, then sources 1 and 3 simultaneously.
//      -> after grant 2, rr_ptr=3, so grant 3 before 1.
//   4. Never pulse i_Tx_Done, TIMEOUT_CLKS=50.
//      -> o_Timeout pulses exactly 50 clk after DV; next request granted next cycle.
//   5. GAP_CLKS=8: done pulse -> next DV no earlier than 10 clk after done (8 gap + IDLE + launch).
//   6. Assert i_Rst_L low mid WAIT_DONE.
//      -> all outputs 0 immediately. After release, a stray done is ignored and a fresh grant starts at source 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte
// sources: latches the winning byte, pulses DV, waits for done or watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 6000,
    parameter int GAP_CLKS     = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [2:0]           o_Grant_Id,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } state_t;

    localparam state_t      POST_FRAME   = (GAP_CLKS == 0) ? ST_IDLE : ST_GAP;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CLKS - 1);

    state_t               state;
    logic [2:0]           rr_ptr;
    logic [15:0]          cnt;

    logic                 sel_valid;
    logic [2:0]           sel_idx;
    logic [7:0]           sel_byte;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [2:0]           next_ptr;

    // Busy status from the transmitter is informational only; sequencing
    // relies solely on the done pulse and the watchdog.
    logic                 unused_tx_active;
    assign unused_tx_active = i_Tx_Active;

    // Rotating priority: the first requester at or after rr_ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!sel_valid && i_Req[i] &&
                    ((int'(rr_ptr) + off) % NUM_REQ) == i) begin
                    sel_valid = 1'b1;
                    sel_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_byte   = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_byte      = i_Req_Byte[8*i +: 8];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr = (o_Grant_Id == 3'(NUM_REQ - 1)) ? 3'd0 : o_Grant_Id + 3'd1;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            o_Ack      <= '0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= '0;
            o_Grant_Id <= '0;
            o_Busy     <= 1'b0;
            o_Timeout  <= 1'b0;
        end else begin
            o_Ack     <= '0;
            o_Tx_DV   <= 1'b0;
            o_Timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        o_Tx_Byte  <= sel_byte;
                        o_Grant_Id <= sel_idx;
                        o_Tx_DV    <= 1'b1;
                        o_Ack      <= sel_onehot;
                        o_Busy     <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Done has priority over a watchdog expiring on the same edge.
                    if (i_Tx_Done || cnt == TIMEOUT_LAST) begin
                        o_Timeout <= !i_Tx_Done;
                        rr_ptr    <= next_ptr;
                        cnt       <= '0;
                        o_Busy    <= (POST_FRAME != ST_IDLE);
                        state     <= POST_FRAME;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        o_Busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    cnt    <= '0;
                    o_Busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
